// File: rtl/step_generator.sv
// Purpose : rhythm-game step sequencer; shows an LFSR-chosen arrow per step, scores comparator hits.
// Latency : SONG_LEN*(BEAT_CYCLES+1) cycles from first SHOW cycle to first DONE cycle.
// Backpr. : none; start is a level request honoured only in IDLE/DONE, ignored while busy.
//
// Ports
//   clk, rst_n     : single clock domain, asynchronous active-low reset
//   start          : level request to (re)start a song
//   hit            : latched comparator point for the step being shown
//   target         : arrow code 1..7 while a step is active, 0 otherwise
//   target_valid   : step window open (SHOW)
//   clk_comp       : one-cycle end-of-window pulse, clears the comparator latch
//   score          : hit steps in the current/last song, saturating at 255
//   step_idx       : 0-based index of the current step
//   busy / done    : song running (SHOW/EVAL) / song finished (DONE)
module step_generator #(
   parameter int unsigned BEAT_CYCLES = 25000000,
   parameter int unsigned SONG_LEN    = 16,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       hit,
   output logic [2:0] target,
   output logic       target_valid,
   output logic       clk_comp,
   output logic [7:0] score,
   output logic [7:0] step_idx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned       CNT_W     = $clog2(BEAT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEAT_CYCLES - 1);
   localparam logic [7:0]        LAST_STEP = 8'(SONG_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      EVAL = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] beat_cnt;
   logic [7:0]       lfsr;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Code 0 means "no press" downstream, so it is remapped to arrow 4.
   function automatic logic [2:0] arrow_of(input logic [7:0] l);
      return (l[2:0] == 3'd0) ? 3'd4 : l[2:0];
   endfunction

   logic [7:0] lfsr_adv;
   assign lfsr_adv = lfsr_next(lfsr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         lfsr         <= LFSR_SEED;
         target       <= 3'd0;
         target_valid <= 1'b0;
         clk_comp     <= 1'b0;
         score        <= 8'd0;
         step_idx     <= 8'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // Score and step_idx hold in DONE until the next start.
               if (start) begin
                  state        <= SHOW;
                  beat_cnt     <= '0;
                  lfsr         <= LFSR_SEED;
                  target       <= arrow_of(LFSR_SEED);
                  target_valid <= 1'b1;
                  clk_comp     <= 1'b0;
                  score        <= 8'd0;
                  step_idx     <= 8'd0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
               end
            end

            SHOW: begin
               if (beat_cnt == CNT_LAST) begin
                  // Last cycle of the window: this is the only cycle hit counts.
                  if (hit && (score != 8'hFF)) begin
                     score <= score + 8'd1;
                  end
                  state        <= EVAL;
                  target_valid <= 1'b0;
                  clk_comp     <= 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end

            EVAL: begin
               clk_comp <= 1'b0;
               if (step_idx == LAST_STEP) begin
                  state  <= DONE;
                  target <= 3'd0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  state        <= SHOW;
                  step_idx     <= step_idx + 8'd1;
                  beat_cnt     <= '0;
                  lfsr         <= lfsr_adv;
                  target       <= arrow_of(lfsr_adv);
                  target_valid <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
